// File: rtl/svm_feat_framer_pkg.sv
// Shared constants and types for the SVM feature framer.
// Optional rounding quantizer is selected by SVM_FEAT_ROUND_EN.
package svm_feat_pkg;

  localparam int N_FEAT     = 4;
  localparam int FEAT_W     = 4;
  localparam int RAW_W      = 8;
  localparam int SHIFT      = RAW_W - FEAT_W;
  localparam int ROUND_HALF = 1 << (SHIFT - 1);
  localparam int IDX_W      = $clog2(N_FEAT);
  localparam int VEC_W      = N_FEAT * FEAT_W;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/svm_feat_framer_if.sv
// Sample-in / vector-out streams between source, framer and classifier.
// slave = framer side, master = source/consumer side.
interface svm_feat_framer_if;
  import svm_feat_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic [RAW_W-1:0] s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [VEC_W-1:0] m_feats;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_feats
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_feats
  );

endinterface

// File: rtl/svm_feat_framer_quant.sv
// RAW_W -> FEAT_W quantizer: truncation, or round-half-up with
// saturation when SVM_FEAT_ROUND_EN is defined.
module svm_feat_quant
  import svm_feat_pkg::*;
(
  input  logic [RAW_W-1:0]  raw_i,
  output logic [FEAT_W-1:0] feat_o
);

`ifdef SVM_FEAT_ROUND_EN
  logic [RAW_W:0]  sum;
  logic [FEAT_W:0] rnd;

  always_comb begin
    sum    = {1'b0, raw_i} + (RAW_W+1)'(ROUND_HALF);
    rnd    = (FEAT_W+1)'(sum >> SHIFT);
    // carry out of the top feature bit means the sample rounded past full scale
    feat_o = rnd[FEAT_W] ? '1 : rnd[FEAT_W-1:0];
  end
`else
  always_comb begin
    feat_o = FEAT_W'(raw_i >> SHIFT);
  end
`endif

endmodule

// File: rtl/svm_feat_framer.sv
// Packs N_FEAT quantized samples into one held vector for the classifier.
// Build with SVM_FEAT_ROUND_EN for rounding instead of truncation.
module svm_feat_framer
  import svm_feat_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  svm_feat_framer_if.slave bus,
  output logic             err_frame_o
);

  state_e                        state_q;
  logic [IDX_W-1:0]              idx_q;
  logic [N_FEAT-1:0][FEAT_W-1:0] feats_q;
  logic                          m_valid_q;
  logic                          err_q;
  logic [FEAT_W-1:0]             feat_d;
  logic                          beat;
  logic                          last_slot;

  svm_feat_quant u_quant (
    .raw_i  (bus.s_data),
    .feat_o (feat_d)
  );

  assign beat      = bus.s_valid && (state_q == COLLECT);
  assign last_slot = (idx_q == IDX_W'(N_FEAT-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      feats_q   <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        COLLECT: begin
          if (beat) begin
            feats_q[idx_q] <= feat_d;
            if (last_slot) begin
              state_q   <= PRESENT;
              m_valid_q <= 1'b1;
              idx_q     <= '0;
              err_q     <= !bus.s_last;
            end else if (bus.s_last) begin
              // early last: drop the partial vector, keep stale slots
              idx_q <= '0;
              err_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        PRESENT: begin
          if (bus.m_ready) begin
            state_q   <= COLLECT;
            m_valid_q <= 1'b0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign bus.s_ready = (state_q == COLLECT);
  assign bus.m_valid = m_valid_q;
  assign bus.m_feats = feats_q;
  assign err_frame_o = err_q;

endmodule

// File: tb/tb_svm_feat_framer.sv
// Directed self-checking bench for svm_feat_framer.
// Rounding expectations follow SVM_FEAT_ROUND_EN.
module tb_svm_feat_framer;

  logic clk;
  logic rst_n;
  logic err_frame;
  int   n_chk;
  int   n_fail;

  svm_feat_framer_if bus ();

  svm_feat_framer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .err_frame_o (err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [7:0] d, input logic l);
    int waited;
    waited = 0;
    while (bus.s_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_chk++;
    if (bus.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout s_ready=%b want 1", bus.s_ready);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1 ||
        bus.m_feats !== 16'h0000 || err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL reset v=%b r=%b f=%h e=%b want 0 1 0000 0",
               bus.m_valid, bus.s_ready, bus.m_feats, err_frame);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_normal();
    bus.m_ready = 1'b1;
    send(8'h10, 1'b0);
    n_chk++;
    if (err_frame !== 1'b0 || bus.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_mid e=%b v=%b want 0 0", err_frame, bus.m_valid);
    end
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    send(8'h45, 1'b1);
    n_chk++;
    if (bus.m_valid !== 1'b1 || bus.m_feats !== 16'h4321 ||
        err_frame !== 1'b0 || bus.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_present v=%b f=%h e=%b r=%b want 1 4321 0 0",
               bus.m_valid, bus.m_feats, err_frame, bus.s_ready);
    end
    @(negedge clk);
    n_chk++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL normal_one_cycle v=%b r=%b want 0 1",
               bus.m_valid, bus.s_ready);
    end
  endtask

  task automatic test_backpressure();
    bus.m_ready = 1'b0;
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    send(8'h45, 1'b1);
    // a held upstream beat must not be consumed while presenting
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (bus.m_valid !== 1'b1 || bus.m_feats !== 16'h4321 ||
          bus.s_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] v=%b f=%h r=%b want 1 4321 0",
                 i, bus.m_valid, bus.m_feats, bus.s_ready);
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    n_chk++;
    if (bus.m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_before_hs v=%b want 1", bus.m_valid);
    end
    @(negedge clk);
    n_chk++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release v=%b r=%b want 0 1",
               bus.m_valid, bus.s_ready);
    end
  endtask

  task automatic test_early_last();
    bus.m_ready = 1'b1;
    send(8'hA0, 1'b0);
    send(8'hB0, 1'b1);
    n_chk++;
    if (err_frame !== 1'b1 || bus.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL early_err e=%b v=%b want 1 0", err_frame, bus.m_valid);
    end
    @(negedge clk);
    n_chk++;
    if (err_frame !== 1'b0 || bus.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL early_pulse e=%b v=%b want 0 0", err_frame, bus.m_valid);
    end
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    send(8'h40, 1'b1);
    n_chk++;
    if (bus.m_valid !== 1'b1 || bus.m_feats !== 16'h4321 ||
        err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL early_recover v=%b f=%h e=%b want 1 4321 0",
               bus.m_valid, bus.m_feats, err_frame);
    end
    @(negedge clk);
  endtask

  task automatic test_missing_last();
    bus.m_ready = 1'b1;
    send(8'hF0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'hF0, 1'b0);
    n_chk++;
    if (err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_mid e=%b want 0", err_frame);
    end
    send(8'hF0, 1'b0);
    n_chk++;
    if (bus.m_valid !== 1'b1 || bus.m_feats !== 16'hFFFF ||
        err_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_present v=%b f=%h e=%b want 1 FFFF 1",
               bus.m_valid, bus.m_feats, err_frame);
    end
    @(negedge clk);
    n_chk++;
    if (err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_pulse e=%b want 0", err_frame);
    end
  endtask

  task automatic test_rounding();
    logic [15:0] exp_v;
`ifdef SVM_FEAT_ROUND_EN
    exp_v = 16'h0F21;
`else
    exp_v = 16'h0F11;
`endif
    bus.m_ready = 1'b1;
    send(8'h17, 1'b0);
    send(8'h18, 1'b0);
    send(8'hF8, 1'b0);
    send(8'h00, 1'b1);
    n_chk++;
    if (bus.m_valid !== 1'b1 || bus.m_feats !== exp_v) begin
      n_fail++;
      $display("FAIL rounding v=%b f=%h want 1 %h",
               bus.m_valid, bus.m_feats, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.m_ready = 1'b1;
    send(8'hC0, 1'b0);
    send(8'hD0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1 ||
        bus.m_feats !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_mid v=%b r=%b f=%h want 0 1 0000",
               bus.m_valid, bus.s_ready, bus.m_feats);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h50, 1'b0);
    send(8'h60, 1'b0);
    send(8'h70, 1'b0);
    send(8'h80, 1'b1);
    n_chk++;
    if (bus.m_valid !== 1'b1 || bus.m_feats !== 16'h8765 ||
        err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_refill v=%b f=%h e=%b want 1 8765 0",
               bus.m_valid, bus.m_feats, err_frame);
    end
    @(negedge clk);
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst_n       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_normal();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_rounding();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
